fpnew_inorder_retire: RTL and testbench
=======================================

Name: fpnew_inorder_retire

Overview:
- In-order completion unit for the FPU top level. It replaces the round-robin output arbiter between the operation-group blocks and the core-facing result port.
- It records the operation group of every issued instruction in an issue-order queue. Only the result of the oldest outstanding instruction is forwarded, so results retire in program order regardless of per-group latency.
- Generalises the arbiter by adding configurable outstanding depth, group count and tag width, plus issue back-pressure, an occupancy count and a flush.

Parameters:
- NumOpGroups, 4, number of operation-group result streams (>=2).
- Width, 64, result width in bits.
- TagWidth, 1, width of the tag carried with each result.
- Depth, 8, maximum number of outstanding instructions (power of two, >=2).
- IdxWidth, $clog2(NumOpGroups), derived; do not override.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all outstanding bookkeeping
- in_valid_i  in  1  issue request from core
- in_opgrp_i  in  IdxWidth  operation group of the issuing instruction
- in_ready_o  out  1  issue accepted when high together with in_valid_i
- opgrp_in_valid_o  out  NumOpGroups  one-hot valid to the selected group block
- opgrp_in_ready_i  in  NumOpGroups  ready from each group block
- opgrp_out_valid_i  in  NumOpGroups  result valid from each group
- opgrp_out_ready_o  out  NumOpGroups  result ready to each group
- opgrp_result_i  in  NumOpGroups*Width  packed group results
- opgrp_status_i  in  NumOpGroups*5  packed status flags (NV,DZ,OF,UF,NX)
- opgrp_tag_i  in  NumOpGroups*TagWidth  packed tags
- result_o  out  Width  retired result
- status_o  out  5  retired status
- tag_o  out  TagWidth  retired tag
- out_valid_o  out  1  retired result valid
- out_ready_i  in  1  core accepts result
- outstanding_o  out  $clog2(Depth)+1  instructions in flight
- busy_o  out  1  outstanding_o != 0

Behaviour:
- State: circular queue of Depth entries of IdxWidth bits, a write pointer, a read pointer and a count (0..Depth). Reset clears pointers and count; the queue contents are don't-care.
- Reset values: in_ready_o=0 only when flush_i=1; otherwise it follows the rules below. out_valid_o=0, opgrp_out_ready_o=0, outstanding_o=0, busy_o=0. result_o, status_o and tag_o are 0.
- Issue: in_ready_o = in_valid_i & ~flush_i & (count<Depth) & opgrp_in_ready_i[in_opgrp_i].
  - opgrp_in_valid_o[g] = in_valid_i & ~flush_i & (count<Depth) & (in_opgrp_i==g).
  - Push in_opgrp_i on the in_valid_i & in_ready_o handshake.
  - No combinational path from out_ready_i to in_ready_o. When full, issue stalls even if a pop happens in the same cycle.
  - in_opgrp_i >= NumOpGroups: never ready, no push.
- Retire: head = queue[rd_ptr], valid when count>0.
  - out_valid_o = (count>0) & opgrp_out_valid_i[head] & ~flush_i.
  - result_o, status_o and tag_o are a combinational mux of the head group's slice (zero latency). When out_valid_o=0 they are 0.
  - opgrp_out_ready_o[g] = (count>0) & (g==head) & out_ready_i & ~flush_i.
  - Pop on the out_valid_o & out_ready_i handshake.
- Non-head groups with valid results are held (ready=0) until they reach the head. Group blocks must keep results in order internally.
- Count update: push only +1; pop only -1; push and pop together leaves count unchanged and advances both pointers. Pointers wrap modulo Depth.
- Flush: count and pointers clear at the next edge. No push and no pop occur in the flush cycle. The group blocks receive the same flush externally.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Outputs return to their reset values.
- outstanding_o = count, registered. busy_o = (count != 0).
- Assertions:
  - No push when full; no pop when empty.
  - A result arriving at a group while count==0 is a protocol error. It is flagged in simulation only.

Test Plan:
- Order across groups: issue ADDMUL (grp0, 3-cycle), then DIVSQRT (grp1, 1-cycle), then CONV (grp3). If grp1 result arrives first it must be held. out_valid_o shows grp0, grp1, grp3 in issue order with tags 0,1,0.
- Full: Depth=8, no results returned, issue 8 -> outstanding_o=8 and in_ready_o=0 on the 9th. A pop in that same cycle still gives in_ready_o=0; the next cycle gives in_ready_o=1.
- Simultaneous push/pop at count=3 -> count stays 3; rd_ptr and wr_ptr both advance. Wrap check: 20 back-to-back single-cycle ops give correct order through pointer wrap.
- Back-pressure: out_ready_i=0 for 5 cycles with head valid -> result_o stable, opgrp_out_ready_o=0. Release -> one pop per cycle.
- Flush with 5 outstanding and in_valid_i=1 -> in_ready_o=0 that cycle; next cycle outstanding_o=0 and busy_o=0; subsequent issue retires normally.
- Async reset mid-stream at count=4 -> out_valid_o=0 and outstanding_o=0 without waiting for a clock edge.

Source files
------------

// File: rtl/fpnew_inorder_retire_if.sv
// Bundle of issue, group-result and retire signals for the in-order completion unit.
// Pure wiring, no latency.
// Handshakes are valid/ready; the direction of each signal is given by the modports.
interface fpnew_inorder_retire_if #(
    parameter int unsigned NumOpGroups = 4,
    parameter int unsigned Width       = 64,
    parameter int unsigned TagWidth    = 1,
    parameter int unsigned Depth       = 8
);
    localparam int unsigned IdxWidth = $clog2(NumOpGroups);
    localparam int unsigned CntWidth = $clog2(Depth) + 1;

    logic                            flush_i;
    logic                            in_valid_i;
    logic [IdxWidth-1:0]             in_opgrp_i;
    logic                            in_ready_o;
    logic [NumOpGroups-1:0]          opgrp_in_valid_o;
    logic [NumOpGroups-1:0]          opgrp_in_ready_i;
    logic [NumOpGroups-1:0]          opgrp_out_valid_i;
    logic [NumOpGroups-1:0]          opgrp_out_ready_o;
    logic [NumOpGroups*Width-1:0]    opgrp_result_i;
    logic [NumOpGroups*5-1:0]        opgrp_status_i;
    logic [NumOpGroups*TagWidth-1:0] opgrp_tag_i;
    logic [Width-1:0]                result_o;
    logic [4:0]                      status_o;
    logic [TagWidth-1:0]             tag_o;
    logic                            out_valid_o;
    logic                            out_ready_i;
    logic [CntWidth-1:0]             outstanding_o;
    logic                            busy_o;

    // Retire unit side
    modport slave (
        input  flush_i, in_valid_i, in_opgrp_i, opgrp_in_ready_i, opgrp_out_valid_i,
               opgrp_result_i, opgrp_status_i, opgrp_tag_i, out_ready_i,
        output in_ready_o, opgrp_in_valid_o, opgrp_out_ready_o, result_o, status_o,
               tag_o, out_valid_o, outstanding_o, busy_o
    );

    // Core / group-block side
    modport master (
        output flush_i, in_valid_i, in_opgrp_i, opgrp_in_ready_i, opgrp_out_valid_i,
               opgrp_result_i, opgrp_status_i, opgrp_tag_i, out_ready_i,
        input  in_ready_o, opgrp_in_valid_o, opgrp_out_ready_o, result_o, status_o,
               tag_o, out_valid_o, outstanding_o, busy_o
    );
endinterface

// File: rtl/fpnew_inorder_retire.sv
// In-order completion unit: tracks issue order of op groups and retires only the oldest result.
// Latency: zero-cycle combinational forward from the head group to the result port.
// Backpressure: issue stalls when full (no same-cycle pop credit); non-head groups are held at ready=0.
module fpnew_inorder_retire #(
    parameter int unsigned NumOpGroups = 4,
    parameter int unsigned Width       = 64,
    parameter int unsigned TagWidth    = 1,
    parameter int unsigned Depth       = 8
) (
    input logic                  clk_i,
    input logic                  rst_ni,
    fpnew_inorder_retire_if.slave bus
);
    localparam int unsigned IdxWidth = $clog2(NumOpGroups);
    localparam int unsigned PtrWidth = $clog2(Depth);
    localparam int unsigned CntWidth = PtrWidth + 1;
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    logic [IdxWidth-1:0] queue_q [Depth];
    logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;

    logic                not_full, not_empty, issue_ok;
    logic                in_rdy, out_vld, head_vld;
    logic                push, pop;
    logic [IdxWidth-1:0] head;

    // Issue side: steer valid to the addressed group; full check uses the registered count only
    always_comb begin
        bus.opgrp_in_valid_o = '0;
        in_rdy               = 1'b0;
        not_full             = (cnt_q != DepthCnt);
        issue_ok             = bus.in_valid_i & ~bus.flush_i & not_full;
        // An out-of-range group matches no g, so it is never ready and never pushed
        for (int g = 0; g < int'(NumOpGroups); g++) begin
            if (bus.in_opgrp_i == IdxWidth'(g)) begin
                bus.opgrp_in_valid_o[g] = issue_ok;
                in_rdy                  = issue_ok & bus.opgrp_in_ready_i[g];
            end
        end
        bus.in_ready_o = in_rdy;
        push           = in_rdy;
    end

    // Retire side: only the group at the head of the issue-order queue may hand over a result
    always_comb begin
        head                  = queue_q[rd_ptr_q];
        not_empty             = (cnt_q != '0);
        head_vld              = 1'b0;
        bus.result_o          = '0;
        bus.status_o          = '0;
        bus.tag_o             = '0;
        bus.opgrp_out_ready_o = '0;
        for (int g = 0; g < int'(NumOpGroups); g++) begin
            if (head == IdxWidth'(g)) begin
                head_vld = bus.opgrp_out_valid_i[g];
            end
        end
        out_vld = not_empty & head_vld & ~bus.flush_i;
        for (int g = 0; g < int'(NumOpGroups); g++) begin
            if (head == IdxWidth'(g)) begin
                bus.opgrp_out_ready_o[g] = not_empty & bus.out_ready_i & ~bus.flush_i;
                if (out_vld) begin
                    bus.result_o = bus.opgrp_result_i[g*Width +: Width];
                    bus.status_o = bus.opgrp_status_i[g*5 +: 5];
                    bus.tag_o    = bus.opgrp_tag_i[g*TagWidth +: TagWidth];
                end
            end
        end
        bus.out_valid_o   = out_vld;
        pop               = out_vld & bus.out_ready_i;
        bus.outstanding_o = cnt_q;
        bus.busy_o        = not_empty;
    end

    // Pointer and count next state; flush wins and clears everything
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (bus.flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrWidth'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrWidth'(1);
            if (push && !pop)      cnt_d = cnt_q + CntWidth'(1);
            else if (pop && !push) cnt_d = cnt_q - CntWidth'(1);
        end
    end

    // Bookkeeping registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Queue payload needs no reset: entries are only read while the count covers them
    always_ff @(posedge clk_i) begin
        if (push) queue_q[wr_ptr_q] <= bus.in_opgrp_i;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> not_full);
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) pop |-> not_empty);
    // A group producing a result with nothing outstanding indicates a broken group block
    a_result_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((|bus.opgrp_out_valid_i) && (cnt_q == '0)));
endmodule

// File: tb/tb_fpnew_inorder_retire.sv
module tb_fpnew_inorder_retire;
    localparam int NG = 4;
    localparam int W  = 64;
    localparam int TW = 1;
    localparam int D  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fpnew_inorder_retire_if #(.NumOpGroups(NG), .Width(W), .TagWidth(TW), .Depth(D)) bus ();

    fpnew_inorder_retire #(.NumOpGroups(NG), .Width(W), .TagWidth(TW), .Depth(D)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    typedef struct {
        logic       v;
        logic [1:0] g;
        logic [3:0] grdy;
        logic       fl;
        logic       exp_rdy;
        logic [3:0] exp_ivld;
    } vec_t;

    typedef struct {
        logic [1:0]  grp;
        logic [63:0] res;
        logic [4:0]  st;
        logic        tag;
        int          rdy;
    } item_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_grp(input int g, input logic v, input logic [63:0] r,
                           input logic [4:0] s, input logic t);
        bus.opgrp_out_valid_i[g]     = v;
        bus.opgrp_result_i[g*W +: W] = r;
        bus.opgrp_status_i[g*5 +: 5] = s;
        bus.opgrp_tag_i[g*TW +: TW]  = t;
    endtask

    task automatic issue(input logic [1:0] g);
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.in_opgrp_i = g;
        #1 chk("issue_rdy", 64'(bus.in_ready_o), 64'd1);
        @(posedge clk);
        #1 bus.in_valid_i = 1'b0;
    endtask

    vec_t  vecs[6];
    item_t exp_q[$];
    int    last_rdy[NG];

    initial begin
        int    cyc;
        logic  exp_ov, exp_ir;
        item_t it;

        bus.flush_i           = 1'b0;
        bus.in_valid_i        = 1'b0;
        bus.in_opgrp_i        = '0;
        bus.opgrp_in_ready_i  = '1;
        bus.opgrp_out_valid_i = '0;
        bus.opgrp_result_i    = '0;
        bus.opgrp_status_i    = '0;
        bus.opgrp_tag_i       = '0;
        bus.out_ready_i       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        chk("rst_outstanding", 64'(bus.outstanding_o), 64'd0);
        chk("rst_busy", 64'(bus.busy_o), 64'd0);
        chk("rst_result", bus.result_o, 64'd0);
        chk("rst_status_tag", 64'({bus.status_o, bus.tag_o}), 64'd0);
        chk("rst_grp_out_rdy", 64'(bus.opgrp_out_ready_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Issue-side combinational vectors at count 0 (valid dropped before the edge)
        vecs[0] = '{1'b1, 2'd0, 4'b1111, 1'b0, 1'b1, 4'b0001};
        vecs[1] = '{1'b1, 2'd2, 4'b1011, 1'b0, 1'b0, 4'b0100};
        vecs[2] = '{1'b1, 2'd3, 4'b1000, 1'b0, 1'b1, 4'b1000};
        vecs[3] = '{1'b1, 2'd1, 4'b1111, 1'b1, 1'b0, 4'b0000};
        vecs[4] = '{1'b0, 2'd1, 4'b1111, 1'b0, 1'b0, 4'b0000};
        vecs[5] = '{1'b1, 2'd1, 4'b0010, 1'b0, 1'b1, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.in_valid_i       = vecs[i].v;
            bus.in_opgrp_i       = vecs[i].g;
            bus.opgrp_in_ready_i = vecs[i].grdy;
            bus.flush_i          = vecs[i].fl;
            #1;
            chk($sformatf("vec%0d_in_ready", i), 64'(bus.in_ready_o), 64'(vecs[i].exp_rdy));
            chk($sformatf("vec%0d_grp_in_vld", i), 64'(bus.opgrp_in_valid_o), 64'(vecs[i].exp_ivld));
            chk($sformatf("vec%0d_out_valid", i), 64'(bus.out_valid_o), 64'd0);
            #1;
            bus.in_valid_i = 1'b0;
            bus.flush_i    = 1'b0;
        end
        bus.opgrp_in_ready_i = '1;
        @(negedge clk);
        #1 chk("vec_outstanding", 64'(bus.outstanding_o), 64'd0);

        // Order across groups: grp1 finishes first but must wait behind grp0
        bus.out_ready_i = 1'b1;
        issue(2'd0);
        issue(2'd1);
        issue(2'd3);
        @(negedge clk);
        set_grp(1, 1'b1, 64'h1111, 5'h02, 1'b1);
        #1;
        chk("ord_cnt3", 64'(bus.outstanding_o), 64'd3);
        chk("ord_held_vld", 64'(bus.out_valid_o), 64'd0);
        chk("ord_held_rdy", 64'(bus.opgrp_out_ready_o), 64'b0001);
        @(negedge clk);
        set_grp(0, 1'b1, 64'h0A0A, 5'h01, 1'b0);
        #1;
        chk("ord_g0_vld", 64'(bus.out_valid_o), 64'd1);
        chk("ord_g0_res", bus.result_o, 64'h0A0A);
        chk("ord_g0_st_tag", 64'({bus.status_o, bus.tag_o}), 64'({5'h01, 1'b0}));
        @(negedge clk);
        set_grp(0, 1'b0, 64'h0, 5'h0, 1'b0);
        #1;
        chk("ord_g1_res", bus.result_o, 64'h1111);
        chk("ord_g1_tag", 64'(bus.tag_o), 64'd1);
        chk("ord_g1_rdy", 64'(bus.opgrp_out_ready_o), 64'b0010);
        @(negedge clk);
        set_grp(1, 1'b0, 64'h0, 5'h0, 1'b0);
        #1 chk("ord_g3_wait", 64'(bus.out_valid_o), 64'd0);
        @(negedge clk);
        set_grp(3, 1'b1, 64'h3333, 5'h10, 1'b0);
        #1;
        chk("ord_g3_res", bus.result_o, 64'h3333);
        chk("ord_g3_tag", 64'(bus.tag_o), 64'd0);
        @(negedge clk);
        set_grp(3, 1'b0, 64'h0, 5'h0, 1'b0);
        #1 chk("ord_empty", 64'(bus.busy_o), 64'd0);
        bus.out_ready_i = 1'b0;

        // Full: a same-cycle pop does not open issue
        for (int i = 0; i < D; i++) issue(2'd0);
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.in_opgrp_i = 2'd0;
        #1;
        chk("full_cnt", 64'(bus.outstanding_o), 64'd8);
        chk("full_rdy", 64'(bus.in_ready_o), 64'd0);
        @(negedge clk);
        set_grp(0, 1'b1, 64'hF0F0, 5'h0, 1'b0);
        bus.out_ready_i = 1'b1;
        #1;
        chk("full_pop_rdy", 64'(bus.in_ready_o), 64'd0);
        chk("full_pop_vld", 64'(bus.out_valid_o), 64'd1);
        @(negedge clk);
        set_grp(0, 1'b0, 64'h0, 5'h0, 1'b0);
        bus.out_ready_i = 1'b0;
        #1;
        chk("full_after_cnt", 64'(bus.outstanding_o), 64'd7);
        chk("full_after_rdy", 64'(bus.in_ready_o), 64'd1);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        #1 chk("full_refill", 64'(bus.outstanding_o), 64'd8);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;

        // Back-pressure: head held stable, then one pop per cycle
        for (int i = 0; i < 3; i++) issue(2'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            set_grp(2, 1'b1, 64'hBEEF_0000_1234_5678, 5'h04, 1'b1);
            #1;
            chk("bp_res", bus.result_o, 64'hBEEF_0000_1234_5678);
            chk("bp_grp_rdy", 64'(bus.opgrp_out_ready_o), 64'd0);
            chk("bp_cnt", 64'(bus.outstanding_o), 64'd3);
        end
        @(negedge clk);
        bus.out_ready_i = 1'b1;
        #1 chk("bp_rel_rdy", 64'(bus.opgrp_out_ready_o), 64'b0100);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            #1 chk("bp_drain_cnt", 64'(bus.outstanding_o), 64'(3 - k));
        end
        @(negedge clk);
        set_grp(2, 1'b0, 64'h0, 5'h0, 1'b0);
        bus.out_ready_i = 1'b0;
        #1 chk("bp_done", 64'(bus.outstanding_o), 64'd0);

        // Flush with 5 outstanding and an issue pending
        for (int i = 0; i < 5; i++) issue(2'd0);
        @(negedge clk);
        bus.in_valid_i = 1'b1;
        bus.in_opgrp_i = 2'd1;
        bus.flush_i    = 1'b1;
        #1;
        chk("fl_in_rdy", 64'(bus.in_ready_o), 64'd0);
        chk("fl_grp_in_vld", 64'(bus.opgrp_in_valid_o), 64'd0);
        @(negedge clk);
        bus.flush_i    = 1'b0;
        bus.in_valid_i = 1'b0;
        #1;
        chk("fl_cnt", 64'(bus.outstanding_o), 64'd0);
        chk("fl_busy", 64'(bus.busy_o), 64'd0);
        issue(2'd2);
        @(negedge clk);
        set_grp(2, 1'b1, 64'hCAFE, 5'h08, 1'b1);
        bus.out_ready_i = 1'b1;
        #1;
        chk("fl_post_vld", 64'(bus.out_valid_o), 64'd1);
        chk("fl_post_res", bus.result_o, 64'hCAFE);
        @(negedge clk);
        set_grp(2, 1'b0, 64'h0, 5'h0, 1'b0);
        bus.out_ready_i = 1'b0;
        #1 chk("fl_post_cnt", 64'(bus.outstanding_o), 64'd0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) issue(2'd1);
        @(negedge clk);
        set_grp(1, 1'b1, 64'h7777, 5'h0, 1'b0);
        #1;
        chk("ar_pre_vld", 64'(bus.out_valid_o), 64'd1);
        chk("ar_pre_cnt", 64'(bus.outstanding_o), 64'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_vld", 64'(bus.out_valid_o), 64'd0);
        chk("ar_cnt", 64'(bus.outstanding_o), 64'd0);
        chk("ar_res", bus.result_o, 64'd0);
        set_grp(1, 1'b0, 64'h0, 5'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomised traffic against an issue-order reference queue
        cyc = 0;
        for (int g = 0; g < NG; g++) last_rdy[g] = 0;
        for (int n = 0; n < 800; n++) begin
            @(negedge clk);
            cyc++;
            chk("rnd_cnt", 64'(bus.outstanding_o), 64'(exp_q.size()));
            chk("rnd_busy", 64'(bus.busy_o), 64'(exp_q.size() != 0));
            // Each group shows its oldest pending result once its latency has elapsed
            for (int g = 0; g < NG; g++) begin
                logic found;
                found = 1'b0;
                set_grp(g, 1'b0, {$urandom, $urandom}, 5'($urandom), 1'($urandom));
                foreach (exp_q[i]) begin
                    if (!found && exp_q[i].grp == 2'(g)) begin
                        found = 1'b1;
                        if (exp_q[i].rdy <= cyc)
                            set_grp(g, 1'b1, exp_q[i].res, exp_q[i].st, exp_q[i].tag);
                    end
                end
            end
            bus.in_valid_i       = ($urandom_range(0, 3) != 0);
            bus.in_opgrp_i       = 2'($urandom_range(0, 3));
            bus.opgrp_in_ready_i = 4'($urandom);
            bus.out_ready_i      = ($urandom_range(0, 3) != 0);
            #1;
            exp_ov = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc);
            chk("rnd_out_vld", 64'(bus.out_valid_o), 64'(exp_ov));
            if (exp_ov) begin
                chk("rnd_res", bus.result_o, exp_q[0].res);
                chk("rnd_st_tag", 64'({bus.status_o, bus.tag_o}), 64'({exp_q[0].st, exp_q[0].tag}));
            end else begin
                chk("rnd_res_zero", bus.result_o, 64'd0);
            end
            exp_ir = bus.in_valid_i && (exp_q.size() < D) && bus.opgrp_in_ready_i[bus.in_opgrp_i];
            chk("rnd_in_rdy", 64'(bus.in_ready_o), 64'(exp_ir));
            if (exp_ov && bus.out_ready_i) void'(exp_q.pop_front());
            if (exp_ir) begin
                int lat;
                case (bus.in_opgrp_i)
                    2'd0:    lat = 3;
                    2'd1:    lat = 1;
                    2'd2:    lat = 2;
                    default: lat = int'($urandom_range(1, 5));
                endcase
                it.grp = bus.in_opgrp_i;
                it.res = {$urandom, $urandom};
                it.st  = 5'($urandom);
                it.tag = 1'($urandom);
                it.rdy = (cyc + lat > last_rdy[it.grp]) ? cyc + lat : last_rdy[it.grp];
                last_rdy[it.grp] = it.rdy;
                exp_q.push_back(it);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
